// File: rtl/jesd204_dac_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : jesd204_dac_cfg_pkg                                    |
// | Description : Register table, reset-register address, FSM states    |
// |               and error codes for the JESD204 DAC configurator.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package jesd204_dac_cfg_pkg;

  // Number of table entries written (and optionally verified) in order.
  localparam int CFG_NUM = 6;

  // Soft-reset register of the DAC transmit path; bit 0 self-clears.
  localparam logic [11:0] RST_ADDR = 12'h004;

  localparam logic [11:0] CFG_ADDR [CFG_NUM] = '{
    12'h010, 12'h014, 12'h018, 12'h01C, 12'h020, 12'h024
  };

  localparam logic [31:0] CFG_DATA [CFG_NUM] = '{
    32'h8000_0101, 32'h0000_00A5, 32'h1234_5678,
    32'h00FF_00FF, 32'hDEAD_BEEF, 32'h0000_0003
  };

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_RESP     = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_REQ   = 4'd1,
    WR_RESP  = 4'd2,
    RD_REQ   = 4'd3,
    RD_RESP  = 4'd4,
    RST_WR   = 4'd5,
    RST_WAIT = 4'd6,
    POLL     = 4'd7,
    DONE     = 4'd8,
    ERR      = 4'd9
  } cfg_state_t;

  // Table lookup by a 5-bit index; out-of-range indices return zero.
  function automatic logic [11:0] cfg_addr(input logic [4:0] idx);
    cfg_addr = '0;
    for (int i = 0; i < CFG_NUM; i++) begin
      if (idx == 5'(i)) cfg_addr = CFG_ADDR[i];
    end
  endfunction

  function automatic logic [31:0] cfg_data(input logic [4:0] idx);
    cfg_data = '0;
    for (int i = 0; i < CFG_NUM; i++) begin
      if (idx == 5'(i)) cfg_data = CFG_DATA[i];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/jesd204_dac_cfg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : jesd204_dac_cfg                                        |
// | Description : AXI-lite master that writes the DAC register table,    |
// |               optionally verifies each write, pulses the transmit    |
// |               soft reset and polls until the PHY reports ready.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module jesd204_dac_cfg
  import jesd204_dac_cfg_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int POLL_GAP    = 64,
  parameter int POLL_MAX    = 256,
  parameter int VERIFY      = 1
) (
  input  logic        clk_50m_bufg,
  input  logic        s_axi_aresetn,
  input  logic        cfg_start,
  input  logic        tx_reset_done,
  output logic [11:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [11:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [1:0]  cfg_err_code,
  output logic [4:0]  cfg_err_idx
);

  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W  = $clog2(POLL_GAP + 1);
  localparam int PCNT_W = $clog2(POLL_MAX + 1);

  localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(POLL_GAP - 1);
  localparam logic [PCNT_W-1:0] PCNT_LIM = PCNT_W'(POLL_MAX);
  localparam logic [4:0]        IDX_LAST = 5'(CFG_NUM - 1);
  localparam logic [4:0]        IDX_RST  = 5'(CFG_NUM);

  cfg_state_t        state, state_nxt;
  logic [4:0]        idx, idx_nxt;
  logic [TMO_W-1:0]  tmo, tmo_nxt;
  logic [GAP_W-1:0]  gap, gap_nxt;
  logic [PCNT_W-1:0] pcnt, pcnt_nxt;

  logic [11:0] awaddr_nxt, araddr_nxt;
  logic [31:0] wdata_nxt;
  logic        awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
  logic        busy_nxt, done_nxt, err_nxt;
  logic [1:0]  err_code_nxt;
  logic [4:0]  err_idx_nxt;

  logic        tmo_zero;
  logic        go_err;
  logic [1:0]  err_sel;
  logic        advance;

  // Strobes are only meaningful while wvalid is high; all lanes always written.
  assign m_axi_wstrb = m_axi_wvalid ? 4'hF : 4'h0;
  assign tmo_zero    = (tmo == '0);

  // Next-state and next-output computation; every AXI output is registered.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    tmo_nxt      = tmo_zero ? tmo : tmo - TMO_W'(1);
    gap_nxt      = gap;
    pcnt_nxt     = pcnt;
    awaddr_nxt   = m_axi_awaddr;
    araddr_nxt   = m_axi_araddr;
    wdata_nxt    = m_axi_wdata;
    awvalid_nxt  = m_axi_awvalid;
    wvalid_nxt   = m_axi_wvalid;
    bready_nxt   = m_axi_bready;
    arvalid_nxt  = m_axi_arvalid;
    rready_nxt   = m_axi_rready;
    busy_nxt     = cfg_busy;
    done_nxt     = cfg_done;
    err_nxt      = cfg_err;
    err_code_nxt = cfg_err_code;
    err_idx_nxt  = cfg_err_idx;
    go_err       = 1'b0;
    err_sel      = ERR_NONE;
    advance      = 1'b0;

    case (state)
      IDLE, DONE, ERR: begin
        if (cfg_start) begin
          state_nxt    = WR_REQ;
          idx_nxt      = '0;
          awaddr_nxt   = cfg_addr(5'd0);
          wdata_nxt    = cfg_data(5'd0);
          awvalid_nxt  = 1'b1;
          wvalid_nxt   = 1'b1;
          busy_nxt     = 1'b1;
          done_nxt     = 1'b0;
          err_nxt      = 1'b0;
          err_code_nxt = ERR_NONE;
          err_idx_nxt  = '0;
          tmo_nxt      = TMO_LOAD;
        end
      end

      // Address and data channels complete independently, in any order.
      WR_REQ, RST_WR: begin
        if (m_axi_awvalid && m_axi_awready) awvalid_nxt = 1'b0;
        if (m_axi_wvalid && m_axi_wready)   wvalid_nxt  = 1'b0;
        if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
          state_nxt  = (state == WR_REQ) ? WR_RESP : RST_WAIT;
          bready_nxt = 1'b1;
          tmo_nxt    = TMO_LOAD;
        end else if (tmo_zero) begin
          go_err  = 1'b1;
          err_sel = ERR_TIMEOUT;
        end
      end

      WR_RESP: begin
        if (m_axi_bvalid) begin
          bready_nxt = 1'b0;
          if (m_axi_bresp != 2'b00) begin
            go_err  = 1'b1;
            err_sel = ERR_RESP;
          end else if (VERIFY != 0) begin
            state_nxt   = RD_REQ;
            araddr_nxt  = m_axi_awaddr;
            arvalid_nxt = 1'b1;
            tmo_nxt     = TMO_LOAD;
          end else begin
            advance = 1'b1;
          end
        end else if (tmo_zero) begin
          go_err  = 1'b1;
          err_sel = ERR_TIMEOUT;
        end
      end

      RD_REQ: begin
        if (m_axi_arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_RESP;
          tmo_nxt     = TMO_LOAD;
        end else if (tmo_zero) begin
          go_err  = 1'b1;
          err_sel = ERR_TIMEOUT;
        end
      end

      RD_RESP: begin
        if (m_axi_rvalid) begin
          rready_nxt = 1'b0;
          if (m_axi_rresp != 2'b00) begin
            go_err  = 1'b1;
            err_sel = ERR_RESP;
          end else if (m_axi_rdata != cfg_data(idx)) begin
            go_err  = 1'b1;
            err_sel = ERR_MISMATCH;
          end else begin
            advance = 1'b1;
          end
        end else if (tmo_zero) begin
          go_err  = 1'b1;
          err_sel = ERR_TIMEOUT;
        end
      end

      RST_WAIT: begin
        if (m_axi_bvalid) begin
          bready_nxt = 1'b0;
          if (m_axi_bresp != 2'b00) begin
            go_err  = 1'b1;
            err_sel = ERR_RESP;
          end else begin
            state_nxt  = POLL;
            gap_nxt    = GAP_LOAD;
            pcnt_nxt   = '0;
            araddr_nxt = RST_ADDR;
            tmo_nxt    = TMO_LOAD;
          end
        end else if (tmo_zero) begin
          go_err  = 1'b1;
          err_sel = ERR_TIMEOUT;
        end
      end

      // Three phases tracked by arvalid/rready: idle gap, address, data.
      POLL: begin
        if (m_axi_arvalid) begin
          if (m_axi_arready) begin
            arvalid_nxt = 1'b0;
            rready_nxt  = 1'b1;
            tmo_nxt     = TMO_LOAD;
          end else if (tmo_zero) begin
            go_err  = 1'b1;
            err_sel = ERR_TIMEOUT;
          end
        end else if (m_axi_rready) begin
          if (m_axi_rvalid) begin
            rready_nxt = 1'b0;
            if (m_axi_rresp != 2'b00) begin
              go_err  = 1'b1;
              err_sel = ERR_RESP;
            end else if (!m_axi_rdata[0] && tx_reset_done) begin
              state_nxt = DONE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else if (pcnt == PCNT_LIM) begin
              go_err  = 1'b1;
              err_sel = ERR_TIMEOUT;
            end else begin
              gap_nxt = GAP_LOAD;
            end
          end else if (tmo_zero) begin
            go_err  = 1'b1;
            err_sel = ERR_TIMEOUT;
          end
        end else if (gap == '0) begin
          arvalid_nxt = 1'b1;
          pcnt_nxt    = pcnt + PCNT_W'(1);
          tmo_nxt     = TMO_LOAD;
        end else begin
          gap_nxt = gap - GAP_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Move to the next table entry, or to the soft-reset write after the last.
    if (advance) begin
      if (idx == IDX_LAST) begin
        idx_nxt    = IDX_RST;
        state_nxt  = RST_WR;
        awaddr_nxt = RST_ADDR;
        wdata_nxt  = 32'h0000_0001;
      end else begin
        idx_nxt    = idx + 5'd1;
        state_nxt  = WR_REQ;
        awaddr_nxt = cfg_addr(idx + 5'd1);
        wdata_nxt  = cfg_data(idx + 5'd1);
      end
      awvalid_nxt = 1'b1;
      wvalid_nxt  = 1'b1;
      tmo_nxt     = TMO_LOAD;
    end

    // Abort: every handshake signal drops; idx already names the failing entry.
    if (go_err) begin
      state_nxt    = ERR;
      awvalid_nxt  = 1'b0;
      wvalid_nxt   = 1'b0;
      bready_nxt   = 1'b0;
      arvalid_nxt  = 1'b0;
      rready_nxt   = 1'b0;
      busy_nxt     = 1'b0;
      err_nxt      = 1'b1;
      err_code_nxt = err_sel;
      err_idx_nxt  = idx;
    end
  end

  // State, counters and registered outputs; reset abandons any sequence.
  always_ff @(posedge clk_50m_bufg or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state         <= IDLE;
      idx           <= '0;
      tmo           <= '0;
      gap           <= '0;
      pcnt          <= '0;
      m_axi_awaddr  <= '0;
      m_axi_araddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      cfg_busy      <= 1'b0;
      cfg_done      <= 1'b0;
      cfg_err       <= 1'b0;
      cfg_err_code  <= ERR_NONE;
      cfg_err_idx   <= '0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      tmo           <= tmo_nxt;
      gap           <= gap_nxt;
      pcnt          <= pcnt_nxt;
      m_axi_awaddr  <= awaddr_nxt;
      m_axi_araddr  <= araddr_nxt;
      m_axi_wdata   <= wdata_nxt;
      m_axi_awvalid <= awvalid_nxt;
      m_axi_wvalid  <= wvalid_nxt;
      m_axi_bready  <= bready_nxt;
      m_axi_arvalid <= arvalid_nxt;
      m_axi_rready  <= rready_nxt;
      cfg_busy      <= busy_nxt;
      cfg_done      <= done_nxt;
      cfg_err       <= err_nxt;
      cfg_err_code  <= err_code_nxt;
      cfg_err_idx   <= err_idx_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jesd204_dac_cfg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_jesd204_dac_cfg                                     |
// | Description : Directed bench for jesd204_dac_cfg with an AXI-lite    |
// |               slave model and fault-injection knobs.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_jesd204_dac_cfg;

  localparam int TMO  = 40;
  localparam int GAP  = 4;
  localparam int PMAX = 5;

  logic        clk_50m_bufg = 1'b0;
  logic        s_axi_aresetn;
  logic        cfg_start;
  logic        tx_reset_done;
  logic [11:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [11:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [1:0]  cfg_err_code;
  logic [4:0]  cfg_err_idx;

  always #10 clk_50m_bufg = ~clk_50m_bufg;

  jesd204_dac_cfg #(
    .TIMEOUT_CYC(TMO),
    .POLL_GAP   (GAP),
    .POLL_MAX   (PMAX),
    .VERIFY     (1)
  ) dut (
    .clk_50m_bufg (clk_50m_bufg),
    .s_axi_aresetn(s_axi_aresetn),
    .cfg_start    (cfg_start),
    .tx_reset_done(tx_reset_done),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .cfg_err_code (cfg_err_code),
    .cfg_err_idx  (cfg_err_idx)
  );

  // Expected write sequence: six table entries then the soft-reset write.
  logic [11:0] exp_addr [7];
  logic [31:0] exp_data [7];

  // Slave behaviour knobs (written only by the stimulus block).
  logic        aw_stuck;
  logic        rst_stuck;
  logic [11:0] wdelay_addr;
  logic [11:0] berr_addr;
  logic [11:0] flip_addr;

  // Slave model state (written only by the model block).
  logic        aw_got, w_got, ar_got;
  logic        p_aw, p_w, p_b, p_ar, p_r;
  logic [11:0] aw_cap, ar_cap, p_awaddr, p_araddr;
  logic [31:0] w_cap, p_wdata;
  logic [31:0] mem [16];
  logic [11:0] wlog_a [16];
  logic [31:0] wlog_d [16];
  int          w_wait;
  int          wr_n, rd_n, poll_n, wv_cnt, traffic;

  int checks = 0;
  int fails  = 0;

  // AXI-lite slave: decides ready/valid on the falling edge, so a handshake
  // decided here completes at the following rising edge.
  always @(negedge clk_50m_bufg) begin
    if (!s_axi_aresetn) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
      m_axi_bvalid  = 1'b0; m_axi_bresp  = 2'b00;
      m_axi_rvalid  = 1'b0; m_axi_rresp  = 2'b00; m_axi_rdata = '0;
      aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
      p_aw = 1'b0; p_w = 1'b0; p_b = 1'b0; p_ar = 1'b0; p_r = 1'b0;
      aw_cap = '0; ar_cap = '0; w_cap = '0; p_awaddr = '0; p_araddr = '0; p_wdata = '0;
      w_wait = 0; wr_n = 0; rd_n = 0; poll_n = 0; wv_cnt = 0; traffic = 0;
    end else begin
      if (p_aw) begin aw_got = 1'b1; aw_cap = p_awaddr; end
      if (p_w)  begin w_got = 1'b1; w_cap = p_wdata; end
      if (p_b)  m_axi_bvalid = 1'b0;
      if (p_ar) begin ar_got = 1'b1; ar_cap = p_araddr; end
      if (p_r)  m_axi_rvalid = 1'b0;
      if (aw_got && w_got) begin
        mem[aw_cap[5:2]] = w_cap;
        if (wr_n < 16) begin wlog_a[wr_n] = aw_cap; wlog_d[wr_n] = w_cap; end
        wr_n++;
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (aw_cap == berr_addr) ? 2'b10 : 2'b00;
        aw_got = 1'b0; w_got = 1'b0;
      end
      if (ar_got) begin
        m_axi_rvalid = 1'b1;
        m_axi_rresp  = 2'b00;
        if (ar_cap == 12'h004) begin
          m_axi_rdata = {31'd0, rst_stuck};
          poll_n++;
        end else begin
          m_axi_rdata = mem[ar_cap[5:2]] ^ ((ar_cap == flip_addr) ? 32'h1 : 32'h0);
          rd_n++;
        end
        ar_got = 1'b0;
      end
      m_axi_awready = m_axi_awvalid && !aw_got && !m_axi_bvalid && !aw_stuck;
      if (m_axi_awready && (m_axi_awaddr == wdelay_addr)) w_wait = 5;
      if (w_wait > 0) begin
        m_axi_wready = 1'b0;
        w_wait--;
      end else begin
        m_axi_wready = m_axi_wvalid && !w_got && !m_axi_bvalid;
      end
      m_axi_arready = m_axi_arvalid && !ar_got && !m_axi_rvalid;
      if (m_axi_wvalid) wv_cnt++;
      if (m_axi_awvalid || m_axi_wvalid || m_axi_bready || m_axi_arvalid || m_axi_rready) traffic++;
      p_aw = m_axi_awready && m_axi_awvalid; p_awaddr = m_axi_awaddr;
      p_w  = m_axi_wready && m_axi_wvalid;   p_wdata  = m_axi_wdata;
      p_b  = m_axi_bvalid && m_axi_bready;
      p_ar = m_axi_arready && m_axi_arvalid; p_araddr = m_axi_araddr;
      p_r  = m_axi_rvalid && m_axi_rready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_50m_bufg);
    s_axi_aresetn = 1'b0;
    repeat (2) @(negedge clk_50m_bufg);
    s_axi_aresetn = 1'b1;
    @(negedge clk_50m_bufg);
  endtask

  task automatic start();
    cfg_start = 1'b1;
    @(negedge clk_50m_bufg);
    cfg_start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int n);
    n = 0;
    while (!(cfg_done || cfg_err) && n < budget) begin
      @(negedge clk_50m_bufg);
      n++;
    end
    chk("end_reached", {31'd0, cfg_done | cfg_err}, 32'd1);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk_50m_bufg);
    #1;
  endtask

  initial begin
    int n;
    int t0;
    int hits;
    exp_addr[0] = 12'h010; exp_data[0] = 32'h8000_0101;
    exp_addr[1] = 12'h014; exp_data[1] = 32'h0000_00A5;
    exp_addr[2] = 12'h018; exp_data[2] = 32'h1234_5678;
    exp_addr[3] = 12'h01C; exp_data[3] = 32'h00FF_00FF;
    exp_addr[4] = 12'h020; exp_data[4] = 32'hDEAD_BEEF;
    exp_addr[5] = 12'h024; exp_data[5] = 32'h0000_0003;
    exp_addr[6] = 12'h004; exp_data[6] = 32'h0000_0001;

    s_axi_aresetn = 1'b1; cfg_start = 1'b0; tx_reset_done = 1'b1;
    aw_stuck = 1'b0; rst_stuck = 1'b0;
    wdelay_addr = 12'hFFF; berr_addr = 12'hFFF; flip_addr = 12'hFFF;
    #5 s_axi_aresetn = 1'b0;
    repeat (2) @(negedge clk_50m_bufg);
    #1;
    chk("rst_flags", {27'd0, cfg_busy, cfg_done, cfg_err, cfg_err_code}, 32'd0);
    chk("rst_err_idx", {27'd0, cfg_err_idx}, 32'd0);
    chk("rst_handshake", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 32'd0);
    chk("rst_addr", {8'd0, m_axi_awaddr, m_axi_araddr}, 32'd0);
    chk("rst_wdata", m_axi_wdata, 32'd0);
    @(negedge clk_50m_bufg);
    s_axi_aresetn = 1'b1;
    @(negedge clk_50m_bufg);

    // Zero-wait responder, full sequence.
    start();
    #1;
    chk("s1_busy", {31'd0, cfg_busy}, 32'd1);
    chk("s1_first_aw", {19'd0, m_axi_awvalid, m_axi_awaddr}, {19'd0, 1'b1, 12'h010});
    chk("s1_wstrb", {28'd0, m_axi_wstrb}, 32'hF);
    wait_end(2000, n);
    settle();
    chk("s1_done", {29'd0, cfg_done, cfg_err, cfg_busy}, 32'b100);
    chk("s1_writes", wr_n, 32'd7);
    chk("s1_reads", rd_n, 32'd6);
    chk("s1_polls", poll_n, 32'd1);
    chk("s1_wvalid_cycles", wv_cnt, 32'd7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("s1_wr_addr%0d", i), {20'd0, wlog_a[i]}, {20'd0, exp_addr[i]});
      chk($sformatf("s1_wr_data%0d", i), wlog_d[i], exp_data[i]);
    end

    // Late wready on entry 2; a second start mid-sequence must be ignored.
    wdelay_addr = 12'h018;
    do_reset();
    start();
    repeat (10) @(negedge clk_50m_bufg);
    start();
    wait_end(2000, n);
    settle();
    chk("s2_done", {30'd0, cfg_done, cfg_err}, 32'b10);
    chk("s2_writes", wr_n, 32'd7);
    chk("s2_wvalid_cycles", wv_cnt, 32'd12);
    hits = 0;
    for (int i = 0; i < 7; i++) if (wlog_a[i] == 12'h018) hits++;
    chk("s2_entry2_once", hits, 32'd1);
    chk("s2_entry2_data", wlog_d[2], 32'h1234_5678);

    // Error write response on entry 3.
    wdelay_addr = 12'hFFF;
    berr_addr = 12'h01C;
    do_reset();
    start();
    wait_end(2000, n);
    settle();
    chk("s3_flags", {29'd0, cfg_done, cfg_err, cfg_busy}, 32'b010);
    chk("s3_code", {30'd0, cfg_err_code}, 32'd1);
    chk("s3_idx", {27'd0, cfg_err_idx}, 32'd3);
    chk("s3_writes", wr_n, 32'd4);
    chk("s3_reads", rd_n, 32'd3);
    t0 = traffic;
    repeat (30) @(negedge clk_50m_bufg);
    #1;
    chk("s3_quiet", traffic - t0, 32'd0);

    // Readback mismatch on entry 1.
    berr_addr = 12'hFFF;
    flip_addr = 12'h014;
    do_reset();
    start();
    wait_end(2000, n);
    settle();
    chk("s4_err", {31'd0, cfg_err}, 32'd1);
    chk("s4_code", {30'd0, cfg_err_code}, 32'd2);
    chk("s4_idx", {27'd0, cfg_err_idx}, 32'd1);
    chk("s4_writes", wr_n, 32'd2);

    // Write address never accepted: timeout after TIMEOUT_CYC cycles.
    flip_addr = 12'hFFF;
    aw_stuck = 1'b1;
    do_reset();
    start();
    wait_end(500, n);
    chk("s5_latency", n, TMO);
    #1;
    chk("s5_code", {30'd0, cfg_err_code}, 32'd3);
    chk("s5_idx", {27'd0, cfg_err_idx}, 32'd0);
    chk("s5_valids_dropped", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd0);

    // Reset bit stuck high: poll limit exhausted.
    aw_stuck = 1'b0;
    rst_stuck = 1'b1;
    do_reset();
    start();
    wait_end(3000, n);
    settle();
    chk("s6_code", {29'd0, cfg_err, cfg_err_code}, 32'b111);
    chk("s6_idx", {27'd0, cfg_err_idx}, 32'd6);
    chk("s6_polls", poll_n, PMAX);
    chk("s6_writes", wr_n, 32'd7);

    // Reset during WR_REQ, then a fresh start replays from entry 0.
    rst_stuck = 1'b0;
    aw_stuck = 1'b1;
    do_reset();
    start();
    repeat (3) @(negedge clk_50m_bufg);
    #1;
    chk("s7_in_wr_req", {30'd0, m_axi_awvalid, cfg_busy}, 32'b11);
    #2 s_axi_aresetn = 1'b0;
    #1;
    chk("s7_valids_drop", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd0);
    chk("s7_flags_clear", {27'd0, cfg_busy, cfg_done, cfg_err, cfg_err_code}, 32'd0);
    repeat (2) @(negedge clk_50m_bufg);
    s_axi_aresetn = 1'b1;
    aw_stuck = 1'b0;
    @(negedge clk_50m_bufg);
    start();
    wait_end(2000, n);
    settle();
    chk("s7_done", {30'd0, cfg_done, cfg_err}, 32'b10);
    chk("s7_replay_addr0", {20'd0, wlog_a[0]}, 32'h010);
    chk("s7_writes", wr_n, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
